// File: rtl/finish_pkg.sv
// Shared encodings for the program-completion monitor: FSM states, finish causes
// and the instruction words that mark the end of a program.
package finish_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_DRAIN = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      CAUSE_NONE = 2'd0,
      CAUSE_SYS  = 2'd1,
      CAUSE_LOOP = 2'd2,
      CAUSE_WD   = 2'd3
   } cause_t;

   localparam logic [31:0] INSTR_ECALL    = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK   = 32'h0010_0073;
   localparam logic [31:0] INSTR_JAL_SELF = 32'h0000_006F;

   function automatic logic is_system(input logic [31:0] instr);
      return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
   endfunction

endpackage

// File: rtl/pc_stall_tracker.sv
// Counts consecutive retires at an unchanged PC; stall_hit is a same-cycle pulse
// on the retire that reaches STALL_LIMIT. Idle cycles neither advance nor clear it.
module pc_stall_tracker
   import finish_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int STALL_LIMIT = 4
)(
   input  logic            clock,
   input  logic            rst,
   input  logic            en,
   input  logic            retire,
   input  logic [XLEN-1:0] pc,
   output logic            stall_hit
);

   logic [XLEN-1:0] prev_pc;
   logic            prev_valid;
   logic [31:0]     stall_cnt;
   logic            upd;
   logic            same_pc;

   assign upd       = en & retire;
   assign same_pc   = prev_valid && (pc == prev_pc);
   assign stall_hit = upd && same_pc && ((stall_cnt + 32'd1) >= 32'(STALL_LIMIT));

   // Counter holds once the limit is reached; the FSM leaves RUN on that retire anyway.
   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         prev_pc    <= '0;
         prev_valid <= 1'b0;
         stall_cnt  <= '0;
      end else if (upd) begin
         prev_pc    <= pc;
         prev_valid <= 1'b1;
         if (!same_pc)
            stall_cnt <= '0;
         else if (!stall_hit)
            stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/finish_detector.sv
// Watches the retire stream and raises a sticky finish_flag DRAIN_CYCLES edges after
// a terminating retire (watchdog: no drain); all outputs registered, no backpressure.
module finish_detector
   import finish_pkg::*;
#(
   parameter int XLEN         = 32,
   parameter int DRAIN_CYCLES = 2,
   parameter int STALL_LIMIT  = 4,
   parameter int WD_MAX       = 1000000
)(
   input  logic            clock,
   input  logic            rst,
   input  logic            retire,
   input  logic [XLEN-1:0] pc,
   input  logic [31:0]     instr,
   output logic            finish_flag,
   output logic [1:0]      finish_cause,
   output logic [XLEN-1:0] halt_pc,
   output logic [31:0]     retired_count
);

   localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 32'd0 : 32'(DRAIN_CYCLES - 1);

   state_t          state, state_nxt;
   cause_t          cause, cause_nxt;
   logic [XLEN-1:0] halt_nxt;
   logic [31:0]     count_nxt;
   logic [31:0]     drain_cnt, drain_nxt;
   logic            stall_hit;
   logic            wd_hit;

   pc_stall_tracker #(
      .XLEN        (XLEN),
      .STALL_LIMIT (STALL_LIMIT)
   ) u_stall (
      .clock     (clock),
      .rst       (rst),
      .en        (state == ST_RUN),
      .retire    (retire),
      .pc        (pc),
      .stall_hit (stall_hit)
   );

   assign wd_hit       = (retired_count != 32'hFFFF_FFFF) &&
                         ((retired_count + 32'd1) == 32'(WD_MAX));
   assign finish_cause = cause;

   always_comb begin
      state_nxt = state;
      cause_nxt = cause;
      halt_nxt  = halt_pc;
      count_nxt = retired_count;
      drain_nxt = drain_cnt;
      case (state)
         ST_RUN: begin
            if (retire) begin
               if (retired_count != 32'hFFFF_FFFF)
                  count_nxt = retired_count + 32'd1;
               // Priority: system call, then self-loop/stall, then watchdog.
               if (is_system(instr) || (instr == INSTR_JAL_SELF) || stall_hit) begin
                  cause_nxt = is_system(instr) ? CAUSE_SYS : CAUSE_LOOP;
                  halt_nxt  = pc;
                  if (DRAIN_CYCLES == 0) begin
                     state_nxt = ST_DONE;
                  end else begin
                     state_nxt = ST_DRAIN;
                     drain_nxt = DRAIN_LOAD;
                  end
               end else if (wd_hit) begin
                  cause_nxt = CAUSE_WD;
                  halt_nxt  = pc;
                  state_nxt = ST_DONE;
               end
            end
         end
         ST_DRAIN: begin
            if (drain_cnt == 32'd0)
               state_nxt = ST_DONE;
            else
               drain_nxt = drain_cnt - 32'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge rst) begin
      if (!rst) begin
         state         <= ST_RUN;
         cause         <= CAUSE_NONE;
         halt_pc       <= '0;
         retired_count <= '0;
         drain_cnt     <= '0;
         finish_flag   <= 1'b0;
      end else begin
         state         <= state_nxt;
         cause         <= cause_nxt;
         halt_pc       <= halt_nxt;
         retired_count <= count_nxt;
         drain_cnt     <= drain_nxt;
         finish_flag   <= (state_nxt == ST_DONE);
      end
   end

endmodule

// File: tb/tb_finish_detector.sv
// Bench for finish_detector: a drain-2 / stall-4 / watchdog-10 instance plus a
// drain-0 / stall-1 instance sharing the same retire stream.
module tb_finish_detector;

   localparam logic [31:0] NOP    = 32'h0000_0013;
   localparam logic [31:0] ECALL  = 32'h0000_0073;
   localparam logic [31:0] EBREAK = 32'h0010_0073;
   localparam logic [31:0] JAL    = 32'h0000_006F;

   typedef struct packed {
      logic        f;
      logic [1:0]  c;
      logic [31:0] h;
      logic [31:0] n;
   } exp_t;

   typedef struct packed {
      logic        r;
      logic [31:0] p;
      logic [31:0] i;
      exp_t        e;
   } vec_t;

   logic        clock = 1'b0;
   logic        rst   = 1'b1;
   logic        retire = 1'b0;
   logic [31:0] pc     = '0;
   logic [31:0] instr  = '0;

   logic        finish_flag, d0_flag;
   logic [1:0]  finish_cause, d0_cause;
   logic [31:0] halt_pc, d0_halt;
   logic [31:0] retired_count, d0_count;

   int   nvec = 0;
   int   errs = 0;
   int   rises = 0;
   exp_t sb[$];

   finish_detector #(.XLEN(32), .DRAIN_CYCLES(2), .STALL_LIMIT(4), .WD_MAX(10)) dut (
      .clock(clock), .rst(rst), .retire(retire), .pc(pc), .instr(instr),
      .finish_flag(finish_flag), .finish_cause(finish_cause),
      .halt_pc(halt_pc), .retired_count(retired_count));

   finish_detector #(.XLEN(32), .DRAIN_CYCLES(0), .STALL_LIMIT(1), .WD_MAX(1000)) dut0 (
      .clock(clock), .rst(rst), .retire(retire), .pc(pc), .instr(instr),
      .finish_flag(d0_flag), .finish_cause(d0_cause),
      .halt_pc(d0_halt), .retired_count(d0_count));

   always #5 clock = ~clock;

   always @(posedge finish_flag) rises++;

   function automatic vec_t mk(input logic r, input logic [31:0] p, input logic [31:0] i,
                               input logic f, input logic [1:0] c,
                               input logic [31:0] h, input logic [31:0] n);
      vec_t v;
      v.r = r; v.p = p; v.i = i;
      v.e.f = f; v.e.c = c; v.e.h = h; v.e.n = n;
      return v;
   endfunction

   function automatic exp_t obs_main();
      return {finish_flag, finish_cause, halt_pc, retired_count};
   endfunction

   function automatic exp_t obs_d0();
      return {d0_flag, d0_cause, d0_halt, d0_count};
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are read at that same point.
   task automatic apply(input logic r, input logic [31:0] p, input logic [31:0] i);
      retire = r; pc = p; instr = i;
      @(posedge clock); #1;
   endtask

   task automatic do_reset();
      retire = 1'b0;
      rst = 1'b0;
      @(posedge clock); #1;
      rst = 1'b1;
   endtask

   task automatic test_reset();
      exp_t e, o;
      rst = 1'b1; #1; rst = 1'b0; #1;
      sb.push_back('0);
      e = sb.pop_front(); o = obs_main(); nvec++;
      if (o !== e) begin errs++; $display("FAIL reset_main: got %h want %h", o, e); end
      sb.push_back('0);
      e = sb.pop_front(); o = obs_d0(); nvec++;
      if (o !== e) begin errs++; $display("FAIL reset_d0: got %h want %h", o, e); end
      @(posedge clock); #1;
      rst = 1'b1;
   endtask

   task automatic test_ecall();
      vec_t v[6];
      exp_t e, o;
      do_reset();
      v[0] = mk(1, 32'h00, NOP,   0, 0, 32'h0, 1);
      v[1] = mk(1, 32'h04, NOP,   0, 0, 32'h0, 2);
      v[2] = mk(1, 32'h08, ECALL, 0, 1, 32'h8, 3);
      v[3] = mk(0, 32'h0C, NOP,   0, 1, 32'h8, 3);
      v[4] = mk(0, 32'h0C, NOP,   1, 1, 32'h8, 3);
      v[5] = mk(1, 32'h0C, NOP,   1, 1, 32'h8, 3);
      for (int k = 0; k < 6; k++) begin
         sb.push_back(v[k].e);
         apply(v[k].r, v[k].p, v[k].i);
         e = sb.pop_front(); o = obs_main(); nvec++;
         if (o !== e) begin errs++; $display("FAIL ecall[%0d]: got %h want %h", k, o, e); end
      end
   endtask

   task automatic test_jal_loop();
      vec_t v[4];
      exp_t e, o;
      do_reset();
      v[0] = mk(1, 32'h40, JAL,   0, 2, 32'h40, 1);
      v[1] = mk(1, 32'h44, ECALL, 0, 2, 32'h40, 1);
      v[2] = mk(1, 32'h48, ECALL, 1, 2, 32'h40, 1);
      v[3] = mk(1, 32'h4C, ECALL, 1, 2, 32'h40, 1);
      for (int k = 0; k < 4; k++) begin
         sb.push_back(v[k].e);
         apply(v[k].r, v[k].p, v[k].i);
         e = sb.pop_front(); o = obs_main(); nvec++;
         if (o !== e) begin errs++; $display("FAIL jal_loop[%0d]: got %h want %h", k, o, e); end
      end
   endtask

   task automatic test_stall();
      vec_t v[10];
      exp_t e, o;
      do_reset();
      v[0] = mk(1, 32'h20, NOP,   0, 0, 32'h0,  1);
      v[1] = mk(1, 32'h20, NOP,   0, 0, 32'h0,  2);
      v[2] = mk(0, 32'h99, ECALL, 0, 0, 32'h0,  2);
      v[3] = mk(0, 32'h99, ECALL, 0, 0, 32'h0,  2);
      v[4] = mk(0, 32'h99, ECALL, 0, 0, 32'h0,  2);
      v[5] = mk(1, 32'h20, NOP,   0, 0, 32'h0,  3);
      v[6] = mk(1, 32'h20, NOP,   0, 0, 32'h0,  4);
      v[7] = mk(1, 32'h20, NOP,   0, 2, 32'h20, 5);
      v[8] = mk(0, 32'h20, NOP,   0, 2, 32'h20, 5);
      v[9] = mk(0, 32'h20, NOP,   1, 2, 32'h20, 5);
      for (int k = 0; k < 10; k++) begin
         sb.push_back(v[k].e);
         apply(v[k].r, v[k].p, v[k].i);
         e = sb.pop_front(); o = obs_main(); nvec++;
         if (o !== e) begin errs++; $display("FAIL stall[%0d]: got %h want %h", k, o, e); end
      end
   endtask

   task automatic test_watchdog();
      exp_t e, o;
      logic [31:0] p;
      do_reset();
      for (int k = 0; k < 11; k++) begin
         p = 32'h100 + 32'(4 * k);
         if (k < 9)       e = '{f: 1'b0, c: 2'd0, h: 32'h0,   n: 32'(k + 1)};
         else             e = '{f: 1'b1, c: 2'd3, h: 32'h124, n: 32'd10};
         sb.push_back(e);
         apply(1'b1, p, (k == 10) ? ECALL : NOP);
         e = sb.pop_front(); o = obs_main(); nvec++;
         if (o !== e) begin errs++; $display("FAIL watchdog[%0d]: got %h want %h", k, o, e); end
      end
   endtask

   task automatic test_priority();
      exp_t e, o;
      logic [31:0] p;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         if (k < 4)       e = '{f: 1'b0, c: 2'd0, h: 32'h0,  n: 32'(k + 1)};
         else if (k < 6)  e = '{f: 1'b0, c: 2'd1, h: 32'h50, n: 32'd5};
         else             e = '{f: 1'b1, c: 2'd1, h: 32'h50, n: 32'd5};
         sb.push_back(e);
         apply(k < 5, 32'h50, (k == 4) ? EBREAK : NOP);
         e = sb.pop_front(); o = obs_main(); nvec++;
         if (o !== e) begin errs++; $display("FAIL prio_stall[%0d]: got %h want %h", k, o, e); end
      end
      do_reset();
      for (int k = 0; k < 12; k++) begin
         p = 32'h300 + 32'(4 * k);
         if (k < 9)       e = '{f: 1'b0, c: 2'd0, h: 32'h0,   n: 32'(k + 1)};
         else if (k < 11) e = '{f: 1'b0, c: 2'd1, h: 32'h324, n: 32'd10};
         else             e = '{f: 1'b1, c: 2'd1, h: 32'h324, n: 32'd10};
         sb.push_back(e);
         apply(k < 10, p, (k == 9) ? EBREAK : NOP);
         e = sb.pop_front(); o = obs_main(); nvec++;
         if (o !== e) begin errs++; $display("FAIL prio_wd[%0d]: got %h want %h", k, o, e); end
      end
   endtask

   task automatic test_drain_zero();
      exp_t e, o;
      do_reset();
      sb.push_back('{f: 1'b1, c: 2'd1, h: 32'h10, n: 32'd1});
      apply(1'b1, 32'h10, ECALL);
      e = sb.pop_front(); o = obs_d0(); nvec++;
      if (o !== e) begin errs++; $display("FAIL drain0_ecall: got %h want %h", o, e); end
      do_reset();
      sb.push_back('{f: 1'b0, c: 2'd0, h: 32'h0, n: 32'd1});
      apply(1'b1, 32'h30, NOP);
      e = sb.pop_front(); o = obs_d0(); nvec++;
      if (o !== e) begin errs++; $display("FAIL stall1_first: got %h want %h", o, e); end
      sb.push_back('{f: 1'b1, c: 2'd2, h: 32'h30, n: 32'd2});
      apply(1'b1, 32'h30, NOP);
      e = sb.pop_front(); o = obs_d0(); nvec++;
      if (o !== e) begin errs++; $display("FAIL stall1_hit: got %h want %h", o, e); end
   endtask

   task automatic test_reset_mid_drain();
      exp_t e, o;
      do_reset();
      sb.push_back('{f: 1'b0, c: 2'd1, h: 32'h0, n: 32'd1});
      apply(1'b1, 32'h0, ECALL);
      e = sb.pop_front(); o = obs_main(); nvec++;
      if (o !== e) begin errs++; $display("FAIL mid_drain_enter: got %h want %h", o, e); end
      apply(1'b0, 32'h4, NOP);
      #2 rst = 1'b0;
      #1;
      sb.push_back('0);
      e = sb.pop_front(); o = obs_main(); nvec++;
      if (o !== e) begin errs++; $display("FAIL mid_drain_reset: got %h want %h", o, e); end
      @(posedge clock); #1;
      rst = 1'b1;
      rises = 0;
      for (int k = 0; k < 5; k++) begin
         if (k < 2) e = '{f: 1'b0, c: 2'd1, h: 32'h100, n: 32'd1};
         else       e = '{f: 1'b1, c: 2'd1, h: 32'h100, n: 32'd1};
         sb.push_back(e);
         apply(k == 0, 32'h100, ECALL);
         e = sb.pop_front(); o = obs_main(); nvec++;
         if (o !== e) begin errs++; $display("FAIL rerun[%0d]: got %h want %h", k, o, e); end
      end
      nvec++;
      if (rises !== 1) begin errs++; $display("FAIL rerun_rises: got %0d want 1", rises); end
   endtask

   initial begin
      test_reset();
      test_ecall();
      test_jal_loop();
      test_stall();
      test_watchdog();
      test_priority();
      test_drain_zero();
      test_reset_mid_drain();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
      $finish;
   end

endmodule
